latch_load_sequencer: RTL and testbench

//   Upstream driver for the gated D latch bank. Synchronises and debounces a raw

---
 rtl/latch_load_sequencer.sv | 113 +++++++++++
 tb/tb_latch_load_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/latch_load_sequencer.sv
// Drives a gated D latch bank: synchronises and debounces a raw load request,
// snapshots the raw data bus, and frames it with a registered enable pulse.
module latch_load_sequencer #(
    parameter int WIDTH        = 4,
    parameter int DEBOUNCE_CYC = 8,
    parameter int EN_CYC       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw_req,
    input  logic [WIDTH-1:0] raw_d,
    output logic [WIDTH-1:0] d_out,
    output logic             e_out,
    output logic             busy,
    output logic [7:0]       load_cnt,
    output logic [2:0]       state_dbg
);

    localparam int DB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int EN_W = (EN_CYC > 1) ? $clog2(EN_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [EN_W-1:0] EN_LAST = EN_W'(EN_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN    = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic              req_s1, req_s2, req_db;
    logic [WIDTH-1:0]  d_s1, d_s2;
    logic [DB_W-1:0]   db_cnt;
    logic [EN_W-1:0]   en_cnt, en_cnt_nxt;
    logic [WIDTH-1:0]  d_nxt;
    logic              e_nxt;
    logic [7:0]        cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
            d_s1   <= '0;
            d_s2   <= '0;
        end else begin
            req_s1 <= raw_req;
            req_s2 <= req_s1;
            d_s1   <= raw_d;
            d_s2   <= d_s1;
        end
    end

    // The counter only runs while the synced level disagrees with req_db, so it
    // counts consecutive differing samples and can never pass DB_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            req_db <= 1'b0;
        end else if (req_s2 == req_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            req_db <= req_s2;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            en_cnt   <= '0;
            d_out    <= '0;
            e_out    <= 1'b0;
            load_cnt <= '0;
        end else begin
            state    <= state_nxt;
            en_cnt   <= en_cnt_nxt;
            d_out    <= d_nxt;
            e_out    <= e_nxt;
            load_cnt <= cnt_nxt;
        end
    end

    // IDLE is only reachable with req_db low, so req_db high in IDLE is a rising edge.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req_db) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = ST_EN;
            ST_EN:    if (en_cnt == EN_LAST) state_nxt = ST_HOLD;
            ST_HOLD:  state_nxt = ST_WAIT;
            ST_WAIT:  if (!req_db) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        d_nxt      = d_out;
        e_nxt      = (state_nxt == ST_EN);
        cnt_nxt    = load_cnt;
        en_cnt_nxt = '0;
        if (state == ST_IDLE && req_db) d_nxt = d_s2;
        if (state == ST_EN) en_cnt_nxt = en_cnt + EN_W'(1);
        if (state == ST_HOLD) cnt_nxt = load_cnt + 8'd1;
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_latch_load_sequencer.sv
// Self-checking bench for latch_load_sequencer: directed scenarios plus random
// presses, checked against a press-level model of expected loads.
module tb_latch_load_sequencer;

    localparam int WIDTH = 4;
    localparam int EN_CYC = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             raw_req = 1'b0;
    logic [WIDTH-1:0] raw_d = '0;
    logic [WIDTH-1:0] d_out;
    logic             e_out;
    logic             busy;
    logic [7:0]       load_cnt;
    logic [2:0]       state_dbg;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [7:0]       exp_cnt = '0;

    latch_load_sequencer #(.WIDTH(WIDTH), .DEBOUNCE_CYC(8), .EN_CYC(EN_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .raw_req(raw_req), .raw_d(raw_d),
        .d_out(d_out), .e_out(e_out), .busy(busy), .load_cnt(load_cnt),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_e();
        int k;
        k = 0;
        while (e_out !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("e_out_timeout", 32'd0, 32'd1);
    endtask

    // One clean press: data held stable, then scrambled after the snapshot.
    task automatic press(input logic [WIDTH-1:0] data, input int hi, input int lo);
        raw_d = data;
        cycles(3);
        exp_q.push_back(data);
        raw_req = 1'b1;
        cycles(12);
        raw_d = WIDTH'($urandom);
        cycles(hi - 12);
        raw_req = 1'b0;
        cycles(lo);
        exp_cnt = exp_cnt + 8'd1;
        check("load_cnt_after_press", {24'd0, load_cnt}, {24'd0, exp_cnt});
        check("busy_after_press", {31'd0, busy}, 32'd0);
    endtask

    // Pulse monitor: every enable window must carry the expected snapshot, last
    // EN_CYC cycles, and have d_out steady one cycle either side.
    logic [WIDTH-1:0] prev_d = '0;
    logic             in_pulse = 1'b0;
    int               width = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_pulse = 1'b0;
            width = 0;
        end else if (e_out && !in_pulse) begin
            in_pulse = 1'b1;
            width = 1;
            pulses++;
            check("d_before_enable", {28'd0, d_out}, {28'd0, prev_d});
            check("load_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) check("d_snapshot", {28'd0, d_out}, {28'd0, exp_q.pop_front()});
        end else if (e_out) begin
            width++;
            check("d_during_enable", {28'd0, d_out}, {28'd0, prev_d});
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            check("enable_width", width, EN_CYC);
            check("d_after_enable", {28'd0, d_out}, {28'd0, prev_d});
        end
        prev_d = d_out;
    end

    initial begin
        int p0;
        logic [7:0] start;

        // Reset state
        cycles(2);
        check("rst_d_out", {28'd0, d_out}, 32'd0);
        check("rst_e_out", {31'd0, e_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_load_cnt", {24'd0, load_cnt}, 32'd0);
        rst_n = 1'b1;
        cycles(3);

        // Reset mid-enable: outputs drop immediately, no partial load counted
        raw_d = 4'h5;
        cycles(3);
        exp_q.push_back(4'h5);
        raw_req = 1'b1;
        wait_e();
        check("mid_en_e_high", {31'd0, e_out}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_e_out", {31'd0, e_out}, 32'd0);
        check("mid_rst_d_out", {28'd0, d_out}, 32'd0);
        check("mid_rst_load_cnt", {24'd0, load_cnt}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        raw_req = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        exp_cnt = '0;
        cycles(5);

        // Clean press with 4'hA
        p0 = pulses;
        press(4'hA, 20, 20);
        check("clean_one_pulse", pulses - p0, 1);
        check("clean_d_kept", {28'd0, d_out}, 32'hA);

        // Bounce shorter than the debounce window
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            raw_req = ~raw_req;
            repeat (3) begin
                @(negedge clk);
                check("bounce_busy", {31'd0, busy}, 32'd0);
            end
        end
        raw_req = 1'b0;
        cycles(15);
        check("bounce_no_pulse", pulses - p0, 0);
        check("bounce_load_cnt", {24'd0, load_cnt}, {24'd0, exp_cnt});

        // Long hold gives one load; release and re-press gives another
        p0 = pulses;
        press(4'h6, 200, 20);
        check("hold_one_pulse", pulses - p0, 1);
        press(4'h9, 20, 20);
        check("repress_pulses", pulses - p0, 2);

        // Release and re-press inside the sequence does not retrigger
        p0 = pulses;
        raw_d = 4'h7;
        cycles(3);
        exp_q.push_back(4'h7);
        raw_req = 1'b1;
        wait_e();
        raw_req = 1'b0;
        cycles(3);
        raw_req = 1'b1;
        cycles(10);
        raw_req = 1'b0;
        cycles(25);
        exp_cnt = exp_cnt + 8'd1;
        check("inseq_one_pulse", pulses - p0, 1);
        check("inseq_load_cnt", {24'd0, load_cnt}, {24'd0, exp_cnt});

        // Data change during enable is ignored until the next load
        raw_d = 4'h3;
        cycles(3);
        exp_q.push_back(4'h3);
        raw_req = 1'b1;
        wait_e();
        raw_d = 4'hC;
        cycles(20);
        check("dchg_held_high", {28'd0, d_out}, 32'h3);
        raw_req = 1'b0;
        cycles(20);
        exp_cnt = exp_cnt + 8'd1;
        check("dchg_held_idle", {28'd0, d_out}, 32'h3);
        check("dchg_load_cnt", {24'd0, load_cnt}, {24'd0, exp_cnt});
        press(4'hC, 20, 20);
        check("dchg_next_load", {28'd0, d_out}, 32'hC);

        // 256 random clean presses wrap load_cnt back to its start value
        start = exp_cnt;
        for (int i = 0; i < 256; i++) begin
            press(WIDTH'($urandom), $urandom_range(16, 24), $urandom_range(14, 20));
        end
        check("wrap_load_cnt", {24'd0, load_cnt}, {24'd0, start});

        cycles(5);
        check("all_loads_seen", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
